// File: rtl/aes_blok_paketleyici_pkg.sv
// Shared widths, output FSM states and the PKCS#7 pad helper for the
// aes_blok_paketleyici byte-to-block packer.
package aes_paket_pkg;
  localparam int BLOK_W      = 128;
  localparam int BAYT_W      = 8;
  localparam int BAYT_SAYISI = 16;

  typedef enum logic [1:0] {BOSTA, GONDER, BEKLE} cikis_durum_t;

  // Pad byte when the message ends on byte index k, i.e. k+1 bytes are present.
  function automatic logic [BAYT_W-1:0] dolgu_degeri(input logic [3:0] k);
    return {4'd0, 4'd15 - k};
  endfunction
endpackage

// File: rtl/aes_blok_paketleyici_fifo.sv
// Block FIFO between the byte packer and aes_engine. A write into a full FIFO
// is only taken when a pop happens on the same edge.
module blok_fifo
  import aes_paket_pkg::*;
#(
  parameter int DERINLIK = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        yaz,
  input  logic                        oku,
  input  logic [BLOK_W-1:0]           veri_g,
  output logic [BLOK_W-1:0]           veri_c,
  output logic                        dolu,
  output logic                        bos,
  output logic [$clog2(DERINLIK):0]   doluluk
);
  localparam int AW = $clog2(DERINLIK);

  logic [BLOK_W-1:0] r_mem [DERINLIK];
  logic [AW-1:0]     r_yaz_ptr;
  logic [AW-1:0]     r_oku_ptr;
  logic [AW:0]       r_sayi;
  logic              w_yaz;
  logic              w_oku;

  assign dolu    = (r_sayi == (AW+1)'(DERINLIK));
  assign bos     = (r_sayi == '0);
  assign w_oku   = oku && !bos;
  assign w_yaz   = yaz && (!dolu || w_oku);
  assign veri_c  = r_mem[r_oku_ptr];
  assign doluluk = r_sayi;

  always_ff @(posedge clk) begin
    if (w_yaz) r_mem[r_yaz_ptr] <= veri_g;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_yaz_ptr <= '0;
      r_oku_ptr <= '0;
      r_sayi    <= '0;
    end else begin
      if (w_yaz) r_yaz_ptr <= r_yaz_ptr + AW'(1);
      if (w_oku) r_oku_ptr <= r_oku_ptr + AW'(1);
      case ({w_yaz, w_oku})
        2'b10:   r_sayi <= r_sayi + (AW+1)'(1);
        2'b01:   r_sayi <= r_sayi - (AW+1)'(1);
        default: r_sayi <= r_sayi;
      endcase
    end
  end
endmodule

// File: rtl/aes_blok_paketleyici.sv
// Packs a byte stream into 128-bit blocks, queues them and issues them to
// aes_engine; AES_PKCS7_DOLGU_EN selects PKCS#7 padding instead of zero-fill.
//   state  | meaning
//   BOSTA  | idle: apply pending key, else start a send when queued and hazir
//   GONDER | one-cycle g_gecerli pulse, pop FIFO head
//   BEKLE  | wait for hazir=0 so a stale hazir cannot re-issue
module aes_blok_paketleyici
  import aes_paket_pkg::*;
#(
  parameter int FIFO_DERINLIK = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [BAYT_W-1:0]                veri,
  input  logic                             veri_gecerli,
  input  logic                             veri_son,
  output logic                             veri_hazir,
  input  logic [BLOK_W-1:0]                anahtar_i,
  input  logic                             anahtar_yaz,
  input  logic                             hazir,
  output logic [BLOK_W-1:0]                blok,
  output logic [BLOK_W-1:0]                anahtar,
  output logic                             g_gecerli,
  output logic [$clog2(FIFO_DERINLIK):0]   doluluk
);
  logic [3:0]        r_sayac;
  logic [BLOK_W-1:0] r_paket;
  logic [BLOK_W-1:0] r_blok;
  logic [BLOK_W-1:0] r_anahtar;
  logic [BLOK_W-1:0] r_anahtar_bek;
  logic              r_anahtar_var;
  cikis_durum_t      r_durum;
  cikis_durum_t      w_sonraki;

  logic              w_al;
  logic              w_son_bayt;
  logic              w_dolgu;
  logic [BAYT_W-1:0] w_dolgu_bayt;
  logic [BLOK_W-1:0] w_blok_yeni;
  logic [BLOK_W-1:0] w_fifo_veri;
  logic [BLOK_W-1:0] w_fifo_cikis;
  logic              w_fifo_yaz;
  logic              w_dolu;
  logic              w_bos;
  logic              w_oku;
  logic              w_blok_al;
  logic              w_anahtar_uygula;

  assign w_son_bayt = (r_sayac == 4'd15);
  assign veri_hazir = rst && !w_dolgu && !(w_dolu && w_son_bayt);
  assign w_al       = veri_gecerli && veri_hazir;

`ifdef AES_PKCS7_DOLGU_EN
  logic r_dolgu;

  // A message ending exactly on a block boundary still needs a full pad block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              r_dolgu <= 1'b0;
    else if (w_al && veri_son && w_son_bayt) r_dolgu <= 1'b1;
    else if (r_dolgu && !w_dolu)           r_dolgu <= 1'b0;
  end

  assign w_dolgu      = r_dolgu;
  assign w_dolgu_bayt = dolgu_degeri(r_sayac);
`else
  assign w_dolgu      = 1'b0;
  assign w_dolgu_bayt = '0;
`endif

  always_comb begin
    w_blok_yeni = '0;
    for (int j = 0; j < BAYT_SAYISI; j++) begin
      if (4'(j) < r_sayac)
        w_blok_yeni[BLOK_W-1-BAYT_W*j -: BAYT_W] = r_paket[BLOK_W-1-BAYT_W*j -: BAYT_W];
      else if (4'(j) == r_sayac)
        w_blok_yeni[BLOK_W-1-BAYT_W*j -: BAYT_W] = veri;
      else
        w_blok_yeni[BLOK_W-1-BAYT_W*j -: BAYT_W] = w_dolgu_bayt;
    end
  end

  assign w_fifo_yaz  = (w_al && (w_son_bayt || veri_son)) || (w_dolgu && !w_dolu);
  assign w_fifo_veri = w_dolgu ? {BAYT_SAYISI{BAYT_W'(BAYT_SAYISI)}} : w_blok_yeni;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sayac <= '0;
      r_paket <= '0;
    end else if (w_al) begin
      r_paket[BLOK_W-1-BAYT_W*r_sayac -: BAYT_W] <= veri;
      r_sayac <= veri_son ? 4'd0 : r_sayac + 4'd1;
    end
  end

  blok_fifo #(.DERINLIK(FIFO_DERINLIK)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .yaz     (w_fifo_yaz),
    .oku     (w_oku),
    .veri_g  (w_fifo_veri),
    .veri_c  (w_fifo_cikis),
    .dolu    (w_dolu),
    .bos     (w_bos),
    .doluluk (doluluk)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_durum <= BOSTA;
    else      r_durum <= w_sonraki;
  end

  always_comb begin
    w_sonraki        = r_durum;
    w_anahtar_uygula = 1'b0;
    w_blok_al        = 1'b0;
    w_oku            = 1'b0;
    unique case (r_durum)
      BOSTA: begin
        if (r_anahtar_var) begin
          w_anahtar_uygula = 1'b1;
        end else if (!w_bos && hazir) begin
          w_blok_al = 1'b1;
          w_sonraki = GONDER;
        end
      end
      GONDER: begin
        w_oku     = 1'b1;
        w_sonraki = BEKLE;
      end
      BEKLE: begin
        if (!hazir) w_sonraki = BOSTA;
      end
      default: w_sonraki = BOSTA;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_blok        <= '0;
      r_anahtar     <= '0;
      r_anahtar_bek <= '0;
      r_anahtar_var <= 1'b0;
    end else begin
      if (anahtar_yaz)       r_anahtar_bek <= anahtar_i;
      if (anahtar_yaz)       r_anahtar_var <= 1'b1;
      else if (w_anahtar_uygula) r_anahtar_var <= 1'b0;
      if (w_anahtar_uygula)  r_anahtar <= r_anahtar_bek;
      if (w_blok_al)         r_blok <= w_fifo_cikis;
    end
  end

  assign blok      = r_blok;
  assign anahtar   = r_anahtar;
  assign g_gecerli = (r_durum == GONDER);
endmodule

// File: tb/tb_aes_blok_paketleyici.sv
// Directed bench for aes_blok_paketleyici: table of packed-block vectors plus
// hand sequences for backpressure, issue-once, key timing and mid-run reset.
module tb_aes_blok_paketleyici;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   veri;
  logic         veri_gecerli;
  logic         veri_son;
  logic         veri_hazir;
  logic [127:0] anahtar_i;
  logic         anahtar_yaz;
  logic         hazir;
  logic [127:0] blok;
  logic [127:0] anahtar;
  logic         g_gecerli;
  logic [$clog2(D):0] doluluk;

  logic hazir_elle;
  logic oto_motor;
  int   motor_bekle = 0;

  // Engine model: after each accepted block it drops hazir for a few cycles.
  assign hazir = oto_motor ? (motor_bekle == 0) : hazir_elle;

  always #5 clk = ~clk;

  aes_blok_paketleyici #(.FIFO_DERINLIK(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .veri         (veri),
    .veri_gecerli (veri_gecerli),
    .veri_son     (veri_son),
    .veri_hazir   (veri_hazir),
    .anahtar_i    (anahtar_i),
    .anahtar_yaz  (anahtar_yaz),
    .hazir        (hazir),
    .blok         (blok),
    .anahtar      (anahtar),
    .g_gecerli    (g_gecerli),
    .doluluk      (doluluk)
  );

  logic [127:0] q[$];
  int n_test = 0;
  int n_fail = 0;

  always @(negedge clk) begin
    if (g_gecerli) begin
      q.push_back(blok);
      motor_bekle = 3;
    end else if (motor_bekle > 0) begin
      motor_bekle = motor_bekle - 1;
    end
  end

  typedef struct {
    int           n;
    logic         son;
    logic [127:0] data;
    logic [127:0] exp;
    int           n_blok;
    logic [127:0] exp2;
  } vek_t;

  vek_t vt[5];

  localparam logic [127:0] K1 = 128'h65787061_6e642033_322d6279_7465206b;
  localparam logic [127:0] K2 = 128'hdeadbeef_01234567_89abcdef_cafef00d;

  task automatic chk(input string ad, input logic [127:0] gercek, input logic [127:0] beklenen);
    n_test++;
    if (gercek !== beklenen) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", ad, gercek, beklenen);
    end
  endtask

  task automatic saat(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bayt_gonder(input logic [7:0] b, input logic son);
    int t = 0;
    veri = b;
    veri_gecerli = 1'b1;
    veri_son = son;
    while (!veri_hazir && t < 300) begin
      saat(1);
      t++;
    end
    if (t >= 300) begin
      n_test++;
      n_fail++;
      $display("FAIL bayt_zaman_asimi: veri_hazir=%b, expected 1 within 300 cycles", veri_hazir);
    end else begin
      saat(1);
    end
    veri_gecerli = 1'b0;
    veri_son = 1'b0;
  endtask

  task automatic blok_bekle(input int n);
    int t = 0;
    while (q.size() < n && t < 300) begin
      saat(1);
      t++;
    end
    chk("blok_sayisi", q.size(), n);
  endtask

  task automatic blok_gonder(input logic [7:0] taban);
    for (int k = 0; k < 16; k++) bayt_gonder(taban + 8'(k), 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{16, 1'b0, 128'h71776572_74797569_6f706173_64666768,
              128'h71776572_74797569_6f706173_64666768, 1, 128'h0};
`ifdef AES_PKCS7_DOLGU_EN
    vt[1] = '{3, 1'b1, 128'h41424300_00000000_00000000_00000000,
              128'h4142430d_0d0d0d0d_0d0d0d0d_0d0d0d0d, 1, 128'h0};
    vt[2] = '{1, 1'b1, 128'hff000000_00000000_00000000_00000000,
              128'hff0f0f0f_0f0f0f0f_0f0f0f0f_0f0f0f0f, 1, 128'h0};
    vt[3] = '{15, 1'b1, 128'h00010203_04050607_08090a0b_0c0d0e00,
              128'h00010203_04050607_08090a0b_0c0d0e01, 1, 128'h0};
    vt[4] = '{16, 1'b1, 128'h00112233_44556677_8899aabb_ccddeeff,
              128'h00112233_44556677_8899aabb_ccddeeff, 2,
              128'h10101010_10101010_10101010_10101010};
`else
    vt[1] = '{3, 1'b1, 128'h41424300_00000000_00000000_00000000,
              128'h41424300_00000000_00000000_00000000, 1, 128'h0};
    vt[2] = '{1, 1'b1, 128'hff000000_00000000_00000000_00000000,
              128'hff000000_00000000_00000000_00000000, 1, 128'h0};
    vt[3] = '{15, 1'b1, 128'h00010203_04050607_08090a0b_0c0d0e00,
              128'h00010203_04050607_08090a0b_0c0d0e00, 1, 128'h0};
    vt[4] = '{16, 1'b1, 128'h00112233_44556677_8899aabb_ccddeeff,
              128'h00112233_44556677_8899aabb_ccddeeff, 1, 128'h0};
`endif

    rst = 1'b0; veri = '0; veri_gecerli = 1'b0; veri_son = 1'b0;
    anahtar_i = '0; anahtar_yaz = 1'b0; hazir_elle = 1'b0; oto_motor = 1'b0;
    #2;
    chk("reset_veri_hazir", veri_hazir, 0);
    chk("reset_blok", blok, 0);
    chk("reset_anahtar", anahtar, 0);
    chk("reset_g_gecerli", g_gecerli, 0);
    chk("reset_doluluk", doluluk, 0);
    saat(2);
    rst = 1'b1;
    saat(1);
    chk("veri_hazir_reset_sonrasi", veri_hazir, 1);

    anahtar_i = K1; anahtar_yaz = 1'b1;
    saat(1);
    anahtar_yaz = 1'b0;
    saat(2);
    chk("anahtar_yukle", anahtar, K1);

    oto_motor = 1'b1;
    for (int i = 0; i < 5; i++) begin
      q.delete();
      for (int k = 0; k < vt[i].n; k++)
        bayt_gonder(vt[i].data[127-8*k -: 8], vt[i].son && (k == vt[i].n - 1));
      blok_bekle(vt[i].n_blok);
      if (q.size() >= 1) chk($sformatf("vektor%0d_blok", i), q[0], vt[i].exp);
      if (vt[i].n_blok > 1 && q.size() >= 2) chk($sformatf("vektor%0d_dolgu", i), q[1], vt[i].exp2);
      saat(8);
      chk($sformatf("vektor%0d_darbe", i), q.size(), vt[i].n_blok);
      chk($sformatf("vektor%0d_doluluk", i), doluluk, 0);
    end

    // hazir held high: one pulse per block, no re-issue until hazir toggles
    oto_motor = 1'b0; hazir_elle = 1'b1; q.delete();
    saat(2);
    blok_gonder(8'ha0);
    blok_bekle(1);
    if (q.size() >= 1) chk("tek_darbe_A", q[0], 128'ha0a1a2a3_a4a5a6a7_a8a9aaab_acadaeaf);
    blok_gonder(8'hb0);
    saat(20);
    chk("tekrar_yok_sayi", q.size(), 1);
    chk("tekrar_yok_doluluk", doluluk, 1);
    hazir_elle = 1'b0;
    saat(1);
    hazir_elle = 1'b1;
    blok_bekle(2);
    if (q.size() >= 2) chk("tek_darbe_B", q[1], 128'hb0b1b2b3_b4b5b6b7_b8b9babb_bcbdbebf);

    // key written during GONDER is applied only after BEKLE->BOSTA
    hazir_elle = 1'b0;
    saat(1);
    hazir_elle = 1'b1;
    begin
      int t = 0;
      blok_gonder(8'hc0);
      while (!g_gecerli && t < 50) begin
        saat(1);
        t++;
      end
      chk("gonder_bulundu", g_gecerli, 1);
    end
    anahtar_i = K2; anahtar_yaz = 1'b1;
    saat(1);
    anahtar_yaz = 1'b0;
    saat(5);
    chk("anahtar_bekle_sirasinda", anahtar, K1);
    hazir_elle = 1'b0;
    saat(1);
    chk("anahtar_bosta_girisi", anahtar, K1);
    saat(1);
    chk("anahtar_bosta_uygula", anahtar, K2);
    saat(2);

    // backpressure: two full blocks queued, third block stalls on byte 16
    rst = 1'b0;
    saat(1);
    rst = 1'b1;
    oto_motor = 1'b0; hazir_elle = 1'b0; q.delete();
    saat(1);
    for (int i = 0; i < 47; i++) bayt_gonder(8'(i), 1'b0);
    chk("dolu_doluluk", doluluk, 2);
    veri = 8'd47; veri_gecerli = 1'b1;
    chk("dolu_veri_hazir_ilk", veri_hazir, 0);
    saat(3);
    chk("dolu_veri_hazir_bekle", veri_hazir, 0);
    chk("dolu_doluluk_sabit", doluluk, 2);
    oto_motor = 1'b1;
    bayt_gonder(8'd47, 1'b0);
    blok_bekle(3);
    if (q.size() >= 3) begin
      chk("dolu_blok0", q[0], 128'h00010203_04050607_08090a0b_0c0d0e0f);
      chk("dolu_blok1", q[1], 128'h10111213_14151617_18191a1b_1c1d1e1f);
      chk("dolu_blok2", q[2], 128'h20212223_24252627_28292a2b_2c2d2e2f);
    end
    saat(10);
    chk("dolu_bosaldi", doluluk, 0);

    // reset in the middle of a send with a partial block pending
    oto_motor = 1'b0; hazir_elle = 1'b0;
    for (int i = 0; i < 37; i++) bayt_gonder(8'h50 + 8'(i), 1'b0);
    chk("rst_oncesi_doluluk", doluluk, 2);
    hazir_elle = 1'b1;
    begin
      int t = 0;
      while (!g_gecerli && t < 50) begin
        saat(1);
        t++;
      end
      chk("rst_oncesi_gonder", g_gecerli, 1);
    end
    rst = 1'b0;
    #1;
    chk("rst_g_gecerli", g_gecerli, 0);
    chk("rst_doluluk", doluluk, 0);
    chk("rst_anahtar", anahtar, 0);
    saat(2);
    rst = 1'b1;
    oto_motor = 1'b1; q.delete();
    saat(1);
    blok_gonder(8'hd0);
    blok_bekle(1);
    if (q.size() >= 1) chk("rst_sonrasi_blok", q[0], 128'hd0d1d2d3_d4d5d6d7_d8d9dadb_dcdddedf);

    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end
endmodule
